// File: rtl/bbs_pkg.sv
// Shared definitions for the Blum-Blum-Shub bit extractor: FSM encoding,
// watchdog length and parameter legality.
package bbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PACK  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Cycles spent in WAIT before the multiplier is declared dead.
  function automatic int TIMEOUT_CYCLES(input int m);
    return 4 * (m + 2);
  endfunction

  function automatic bit params_legal(input int m, input int w, input int k);
    return (k >= 1) && (k <= m) && ((w % k) == 0);
  endfunction

endpackage

// File: rtl/bbs_cond_sub.sv
// Conditional subtraction r = (val >= n) ? val - n : val for an (M+2)-bit value
// nominally in [0, 2n); ge2n flags inputs outside that range.
module bbs_cond_sub #(
  parameter int M = 8
) (
  input  logic [M+1:0] val,
  input  logic [M-1:0] n,
  output logic [M-1:0] r,
  output logic         ge2n
);

  logic ge_n_s;

  // Single subtraction; the low M bits of val - n are exact whenever val < 2n.
  always_comb begin
    ge_n_s = (val >= {2'b00, n});
    ge2n   = (val >= {1'b0, n, 1'b0});
    if (ge_n_s) begin
      r = val[M-1:0] - n;
    end else begin
      r = val[M-1:0];
    end
  end

endmodule

// File: rtl/bbs_bit_extractor.sv
// BBS state holder and bit harvester behind a Montgomery squarer.
// Optional WAIT watchdog enabled by defining BBS_TIMEOUT_EN.
module bbs_bit_extractor #(
  parameter int M = 8,
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   N,
  input  logic [M-1:0]   seed,
  input  logic           seed_load,
  input  logic           run,
  output logic           mmm_start,
  output logic [M-1:0]   mmm_a,
  input  logic           mmm_done,
  input  logic [M+1:0]   mmm_out,
  output logic           rnd_valid,
  input  logic           rnd_ready,
  output logic [W-1:0]   rnd_data,
  output logic           busy,
  output logic           err
);
  import bbs_pkg::*;

  localparam int CNT_W = $clog2(W + 1);

  generate
    if (!params_legal(M, W, K)) begin : g_param_check
      $error("bbs_bit_extractor: need 1 <= K <= M and W a multiple of K");
    end
  endgenerate

`ifdef BBS_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_CYCLES(M);
  localparam int WD_W   = $clog2(TO_CYC + 1);
  logic [WD_W-1:0] wd_r;
`endif

  state_t         state_r;
  logic [M-1:0]   x_r;
  logic [W-1:0]   sreg_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]     stale_r;
  logic           mmm_start_r;
  logic           rnd_valid_r;
  logic [W-1:0]   rnd_data_r;
  logic           busy_r;
  logic           err_r;

  logic [M-1:0]   red_s;
  logic           ge2n_s;
  logic           done_live_s;
  logic           stale_dec_s;
  logic           stale_inc_s;
  logic [1:0]     stale_nxt_s;
  logic [W-1:0]   sreg_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic           word_full_s;
  logic           out_free_s;

  bbs_cond_sub #(.M(M)) u_cond_sub (
    .val  (mmm_out),
    .n    (N),
    .r    (red_s),
    .ge2n (ge2n_s)
  );

  // Harvest step and in-flight bookkeeping; stale_r counts dones still owed
  // by aborted requests so they are never mistaken for the current result.
  always_comb begin
    sreg_nxt_s  = (sreg_r << K) | W'(x_r[K-1:0]);
    cnt_nxt_s   = cnt_r + CNT_W'(K);
    word_full_s = (cnt_nxt_s == CNT_W'(W));
    out_free_s  = !rnd_valid_r || rnd_ready;
    done_live_s = mmm_done && (stale_r == 2'd0);
    stale_dec_s = mmm_done && (stale_r != 2'd0);
    stale_inc_s = seed_load && (state_r == ST_WAIT) && !done_live_s;
    if (stale_dec_s && !stale_inc_s) begin
      stale_nxt_s = stale_r - 2'd1;
    end else if (stale_inc_s && !stale_dec_s && (stale_r != 2'd3)) begin
      stale_nxt_s = stale_r + 2'd1;
    end else begin
      stale_nxt_s = stale_r;
    end
  end

  // Main FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      x_r         <= '0;
      sreg_r      <= '0;
      cnt_r       <= '0;
      stale_r     <= 2'd0;
      mmm_start_r <= 1'b0;
      rnd_valid_r <= 1'b0;
      rnd_data_r  <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef BBS_TIMEOUT_EN
      wd_r        <= '0;
`endif
    end else begin
      mmm_start_r <= 1'b0;
      stale_r     <= stale_nxt_s;
      if (rnd_valid_r && rnd_ready) begin
        rnd_valid_r <= 1'b0;
      end
      if (seed_load) begin
        x_r     <= seed;
        sreg_r  <= '0;
        cnt_r   <= '0;
        err_r   <= 1'b0;
        busy_r  <= 1'b1;
        state_r <= ST_ISSUE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy_r <= 1'b0;
          end
          ST_ISSUE: begin
            if (run) begin
              mmm_start_r <= 1'b1;
              state_r     <= ST_WAIT;
`ifdef BBS_TIMEOUT_EN
              wd_r        <= '0;
`endif
            end else begin
              sreg_r  <= '0;
              cnt_r   <= '0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (done_live_s) begin
              x_r     <= red_s;
              state_r <= ST_PACK;
              if (ge2n_s) begin
                err_r <= 1'b1;
              end
            end
`ifdef BBS_TIMEOUT_EN
            else if (wd_r == WD_W'(TO_CYC - 1)) begin
              err_r   <= 1'b1;
              sreg_r  <= '0;
              cnt_r   <= '0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              wd_r <= wd_r + WD_W'(1);
            end
`endif
          end
          ST_PACK: begin
            if (word_full_s && out_free_s) begin
              rnd_data_r  <= sreg_nxt_s;
              rnd_valid_r <= 1'b1;
              sreg_r      <= '0;
              cnt_r       <= '0;
              state_r     <= ST_ISSUE;
            end else if (word_full_s) begin
              sreg_r  <= sreg_nxt_s;
              cnt_r   <= cnt_nxt_s;
              state_r <= ST_HOLD;
            end else begin
              sreg_r  <= sreg_nxt_s;
              cnt_r   <= cnt_nxt_s;
              state_r <= ST_ISSUE;
            end
          end
          ST_HOLD: begin
            if (out_free_s) begin
              rnd_data_r  <= sreg_r;
              rnd_valid_r <= 1'b1;
              sreg_r      <= '0;
              cnt_r       <= '0;
              state_r     <= ST_ISSUE;
            end
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mmm_start = mmm_start_r;
  assign mmm_a     = x_r;
  assign rnd_valid = rnd_valid_r;
  assign rnd_data  = rnd_data_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bbs_bit_extractor.sv
// Directed bench for bbs_bit_extractor (M=8, N=209, W=8, K=1) with a
// fixed-latency multiplier stub; covers BBS_TIMEOUT_EN in either build.
module tb_bbs_bit_extractor;

  localparam int LAT = 3;

  logic       clk;
  logic       rst;
  logic [7:0] n_mod;
  logic [7:0] seed;
  logic       seed_load;
  logic       run;
  logic       mmm_start;
  logic [7:0] mmm_a;
  logic       mmm_done;
  logic [9:0] mmm_out;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [7:0] rnd_data;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit stub_en = 1'b1;
  int stub_v;
  int resp_q[$];
  int pend_due[$];
  int pend_val[$];
  logic any_start;

  bbs_bit_extractor #(.M(8), .W(8), .K(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .N         (n_mod),
    .seed      (seed),
    .seed_load (seed_load),
    .run       (run),
    .mmm_start (mmm_start),
    .mmm_a     (mmm_a),
    .mmm_done  (mmm_done),
    .mmm_out   (mmm_out),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: answers each mmm_start LAT cycles later with the next queued value.
  initial begin
    mmm_done = 1'b0;
    mmm_out  = 10'd0;
    forever begin
      @(negedge clk);
      cyc++;
      mmm_done = 1'b0;
      mmm_out  = 10'd0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mmm_done = 1'b1;
        mmm_out  = 10'(pend_val[0]);
        void'(pend_due.pop_front());
        void'(pend_val.pop_front());
      end
      if (stub_en && mmm_start) begin
        stub_v = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
        pend_due.push_back(cyc + LAT);
        pend_val.push_back(stub_v);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_seed(input logic [7:0] v);
    seed      = v;
    seed_load = 1'b1;
    tick(1);
    seed_load = 1'b0;
  endtask

  // Wait for the stub to present a result, then step past the sampling edge.
  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mmm_done) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq({tag, "_done_seen"}, found, 1'b1);
    tick(1);
  endtask

  task automatic wait_start(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mmm_start) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq({tag, "_start_seen"}, found, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq({tag, "_idle"}, found, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    n_mod     = 8'd209;
    seed      = 8'd0;
    seed_load = 1'b0;
    run       = 1'b1;
    rnd_ready = 1'b1;
    tick(2);
    check_eq("rst_start", mmm_start, 1'b0);
    check_eq("rst_a", mmm_a, 8'd0);
    check_eq("rst_valid", rnd_valid, 1'b0);
    check_eq("rst_data", rnd_data, 8'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    rst = 1'b1;
    tick(3);
    check_eq("idle_run_only", busy, 1'b0);

    // Reduction: 250 -> 41, 100 -> 100, 209 -> 0
    resp_q = '{250, 100, 209};
    pulse_seed(8'd3);
    check_eq("red_busy", busy, 1'b1);
    check_eq("red_no_early_start", mmm_start, 1'b0);
    tick(1);
    check_eq("red_start", mmm_start, 1'b1);
    check_eq("red_a_seed", mmm_a, 8'd3);
    wait_done("red1");
    check_eq("red_250", mmm_a, 8'd41);
    wait_done("red2");
    check_eq("red_100", mmm_a, 8'd100);
    wait_done("red3");
    check_eq("red_209", mmm_a, 8'd0);
    check_eq("red_err", err, 1'b0);
    run = 1'b0;
    wait_idle("red");
    run = 1'b1;

    // Packing: alternating LSBs build 8'hAA
    resp_q = '{1, 0, 1, 0, 1, 0, 1, 0};
    pulse_seed(8'd7);
    for (int i = 0; i < 8; i++) wait_done("pack");
    check_eq("pack_valid_early", rnd_valid, 1'b0);
    tick(1);
    check_eq("pack_valid", rnd_valid, 1'b1);
    check_eq("pack_data", rnd_data, 8'hAA);
    check_eq("pack_no_start", mmm_start, 1'b0);
    tick(1);
    check_eq("pack_valid_drop", rnd_valid, 1'b0);
    check_eq("pack_next_start", mmm_start, 1'b1);
    run = 1'b0;
    wait_done("pack_tail");
    wait_idle("pack");
    run = 1'b1;

    // Backpressure: word F0 held, word 3C parked in HOLD
    rnd_ready = 1'b0;
    resp_q = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 2, 2};
    pulse_seed(8'd11);
    for (int i = 0; i < 8; i++) wait_done("bp_a");
    tick(1);
    check_eq("bp_first_valid", rnd_valid, 1'b1);
    check_eq("bp_first_data", rnd_data, 8'hF0);
    for (int i = 0; i < 8; i++) wait_done("bp_b");
    tick(1);
    any_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      any_start = any_start | mmm_start;
      tick(1);
    end
    check_eq("bp_hold_no_start", any_start, 1'b0);
    check_eq("bp_hold_data", rnd_data, 8'hF0);
    check_eq("bp_hold_valid", rnd_valid, 1'b1);
    check_eq("bp_hold_busy", busy, 1'b1);
    rnd_ready = 1'b1;
    tick(1);
    check_eq("bp_second_data", rnd_data, 8'h3C);
    check_eq("bp_second_valid", rnd_valid, 1'b1);
    check_eq("bp_second_no_start", mmm_start, 1'b0);
    tick(1);
    check_eq("bp_drained", rnd_valid, 1'b0);
    check_eq("bp_resume", mmm_start, 1'b1);
    run = 1'b0;
    wait_done("bp_tail");
    wait_idle("bp");
    run = 1'b1;

    // Error: 420 >= 2N, reduced once to 211
    resp_q = '{420, 100};
    pulse_seed(8'd1);
    wait_done("err1");
    check_eq("err_set", err, 1'b1);
    check_eq("err_a", mmm_a, 8'd211);
    wait_done("err2");
    check_eq("err_continue", mmm_a, 8'd100);
    check_eq("err_sticky", err, 1'b1);
    run = 1'b0;
    wait_idle("err");
    check_eq("err_idle_sticky", err, 1'b1);
    run = 1'b1;

    // Abort: seed_load mid-WAIT, late result must be dropped
    resp_q = '{50, 77};
    pulse_seed(8'd20);
    check_eq("err_cleared", err, 1'b0);
    wait_start("abort");
    tick(1);
    pulse_seed(8'd5);
    tick(2);
    check_eq("abort_late_ignored", mmm_a, 8'd5);
    wait_done("abort_new");
    check_eq("abort_new_result", mmm_a, 8'd77);
    run = 1'b0;
    wait_idle("abort");
    run = 1'b1;

    // Asynchronous reset while waiting on the multiplier
    pulse_seed(8'd33);
    wait_start("arst");
    tick(1);
    check_eq("arst_pre_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("arst_a", mmm_a, 8'd0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_valid", rnd_valid, 1'b0);
    check_eq("arst_data", rnd_data, 8'd0);
    check_eq("arst_start", mmm_start, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(6);
    check_eq("arst_stays_idle", busy, 1'b0);

    // Silent multiplier
    stub_en = 1'b0;
    pulse_seed(8'd2);
    wait_start("wd");
`ifdef BBS_TIMEOUT_EN
    tick(39);
    check_eq("wd_busy_39", busy, 1'b1);
    check_eq("wd_err_39", err, 1'b0);
    tick(1);
    check_eq("wd_busy_40", busy, 1'b0);
    check_eq("wd_err_40", err, 1'b1);
`else
    tick(1000);
    check_eq("nowd_busy", busy, 1'b1);
    check_eq("nowd_err", err, 1'b0);
    check_eq("nowd_a", mmm_a, 8'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bbs_bit_extractor.md
# bbs_bit_extractor

Downstream stage of the radix-2 Montgomery multiplier datapath in the Blum-Blum-Shub generator. It holds the BBS state x, issues one Montgomery squaring per iteration, and consumes the (M+2)-bit result. It reduces that result to [0, N), feeds it back as the next operand, and harvests K low bits per iteration into W-bit random words. Words leave on a valid/ready stream.

## Interface
Parameters:
- M, 8: modulus/operand width
- W, 8: output word width; must be a multiple of K
- K, 1: bits harvested per iteration, 1..M

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- N  in  M  modulus; stable while busy
- seed  in  M  initial x
- seed_load  in  1  one-cycle pulse: load seed, start iterating
- run  in  1  level; iterations issue only while high
- mmm_start  out  1  one-cycle pulse requesting x·x·R⁻¹ mod N
- mmm_a  out  M  operand (both A and B); held from mmm_start until mmm_done
- mmm_done  in  1  one-cycle pulse; mmm_out valid
- mmm_out  in  M+2  multiplier result, nominally in [0, 2N)
- rnd_valid  out  1  rnd_data valid
- rnd_ready  in  1  consumer accepts
- rnd_data  out  W  random word
- busy  out  1  not in IDLE
- err  out  1  sticky; cleared only by reset or seed_load

## Operation
- States: IDLE, ISSUE, WAIT, PACK, HOLD.
- IDLE:
  - On seed_load: x←seed, shift register and bit count cleared, err cleared, go to ISSUE.
  - run alone does not leave IDLE.
- ISSUE:
  - If run=1: pulse mmm_start for one cycle, go to WAIT.
  - If run=0: go to IDLE. x is retained, and the partial word is discarded.
- WAIT:
  - On mmm_done, reduce: r = mmm_out ≥ N ? mmm_out−N : mmm_out, truncated to M bits.
  - If mmm_out ≥ 2N, set err; r is still a single subtraction.
  - Then x←r and go to PACK.
- PACK:
  - Shift left: sreg←{sreg[W−K−1:0], x[K−1:0]}, count+=K. The first harvested bit ends in the MSB.
  - If count reaches W and the output register is empty or draining this cycle (rnd_valid & rnd_ready): load rnd_data, assert rnd_valid, reset count, go to ISSUE.
  - If count reaches W and the output register is occupied: go to HOLD.
  - Otherwise go to ISSUE.
- HOLD:
  - No mmm_start is issued.
  - When the output register frees (accept observed), transfer the word and go to ISSUE.
- Output stream:
  - rnd_data is stable while rnd_valid & !rnd_ready.
  - rnd_valid drops in the cycle after acceptance unless a new word is loaded in that same cycle.
- seed_load in any non-IDLE state aborts the current iteration: x←seed, count/sreg cleared, go to ISSUE.
  - Any mmm_done already in flight for the aborted request is ignored.
  - The output register is unaffected.
- mmm_done outside WAIT is ignored.
- Reset values: mmm_start=0, mmm_a=0, rnd_valid=0, rnd_data=0, busy=0, err=0, state IDLE, x=0, count=0.
- Reset mid-operation takes effect immediately (asynchronous assert); the iteration is lost.

## Timing
- seed_load at edge t → mmm_start high in the cycle after edge t+1 (ISSUE).
- mmm_done sampled at edge t → x updated at t; PACK at edge t+1; rnd_valid high after t+1 when a word completes.
- Next mmm_start in the cycle after PACK, so iteration overhead is 3 cycles plus multiplier latency.
- mmm_a changes only at the x update; it is never changed during WAIT.
- Throughput: one word per W/K iterations when rnd_ready=1.

## Configuration
- BBS_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT.
  - At 4·(M+2) cycles without mmm_done: set err, go to IDLE, discard the partial word.
- BBS_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely.

## Structure
- Package bbs_pkg contains:
  - state enum
  - TIMEOUT_CYCLES(M) constant function
  - parameter legality checks: W%K==0, 1≤K≤M
- One sub-module, bbs_cond_sub:
  - combinational r = x ≥ N ? x−N : x, with a ge2n flag
  - reused later for Montgomery-domain exit.

## Test plan
Test configuration: M=8, N=209, W=8, K=1. A behavioural multiplier stub drives mmm_out a fixed number of cycles after mmm_start.
- Reduction: stub returns 250, 100, 209 → mmm_a becomes 41, 100, 0; err stays 0.
- Packing: stub returns 1,0,1,0,1,0,1,0 (odd/even) with rnd_ready=1 → rnd_data=8'hAA, rnd_valid high one cycle, next mmm_start 1 cycle after PACK.
- Backpressure: rnd_ready=0 for 16 iterations → first word is held stable; second word completes, state HOLD, no mmm_start. Raise rnd_ready → first word accepted, second presented the next cycle, iteration resumes.
- Error: stub returns 420 (≥418) → err=1, mmm_a=211, iteration continues. err persists until seed_load.
- Abort/reset:
  - seed_load seed=5 during WAIT → late mmm_done ignored, next mmm_a=5.
  - rst=0 in WAIT → all outputs 0 immediately, busy=0.
- Timeout (BBS_TIMEOUT_EN): no mmm_done for 40 cycles → err=1, busy=0 after the 40th cycle. Without the macro, the block is still busy in WAIT at cycle 1000.
